// File: rtl/execute_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : execute_muldiv_unit
// Description : Iterative RV32M/RV64M multiply/divide engine for the execute
//               phase. Shift-add multiply and restoring divide retire
//               RADIX_BITS bits per CALC cycle. Execute is stalled until the
//               result is ready, then the result and its rd are registered
//               for the memory-access stage.
//               Optional macro MULDIV_EARLY_OUT_EN: trivial operations
//               (divide by zero, signed overflow, unsigned divide by one,
//               MUL/MULHU with a zero operand) skip the CALC phase.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_muldiv_unit #(
   parameter int XLEN       = 32,
   parameter int RADIX_BITS = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            phase_execute,
   input  logic            muldiv_req,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1data_de,
   input  logic [XLEN-1:0] rs2data_de,
   input  logic [4:0]      rdsel_de,
   input  logic            flush,
   output logic            stall_execute,
   output logic            muldiv_valid_em,
   output logic [XLEN-1:0] muldiv_out_em,
   output logic [4:0]      rdsel_em
);

   localparam int ITER  = XLEN / RADIX_BITS;
   localparam int CNT_W = $clog2(ITER);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      CALC = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t state, state_nx;

   // Latched request
   logic [2:0]      op;
   logic [XLEN-1:0] opa, opb;
   logic [4:0]      rd;

   // Working registers: hi = product high / partial remainder,
   // lo = multiplier then product low / dividend then quotient.
   logic [XLEN-1:0] mag_b;
   logic [XLEN-1:0] hi, lo;
   logic [CNT_W-1:0] cnt;
   logic            neg_q, neg_r;
   logic [XLEN-1:0] result;

   // Operand decode
   logic            accept;
   logic            is_div;
   logic            sign_a, sign_b;
   logic            a_neg, b_neg, b_zero;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            neg_q_nx;

   // PREP load values (bypass values when early-out applies)
   logic            early;
   logic [XLEN-1:0] prep_hi, prep_lo;

   // One CALC step
   logic [XLEN+RADIX_BITS-1:0] addend, psum;
   logic [XLEN-1:0]            mul_hi, mul_lo;
   logic [XLEN:0]              trial;
   logic [XLEN-1:0]            rem_t, quo_t;
   logic [XLEN-1:0]            step_hi, step_lo;

   // Sign correction and result select
   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0]   q_s, r_s, fix_res;

   assign accept = (state == IDLE) & phase_execute & muldiv_req;
   assign is_div = op[2];
   assign sign_a = (op == 3'b001) | (op == 3'b010) | (op == 3'b100) | (op == 3'b110);
   assign sign_b = (op == 3'b001) | (op == 3'b100) | (op == 3'b110);
   assign a_neg  = sign_a & opa[XLEN-1];
   assign b_neg  = sign_b & opb[XLEN-1];
   assign a_mag  = a_neg ? -opa : opa;
   assign b_mag  = b_neg ? -opb : opb;
   assign b_zero = (opb == '0);
   // A zero divisor yields an all-ones quotient regardless of operand signs.
   assign neg_q_nx = is_div ? ((a_neg ^ b_neg) & ~b_zero) : (a_neg ^ b_neg);

`ifdef MULDIV_EARLY_OUT_EN
   logic div_zero, div_ovf, divu_one, mul_zero;
   assign div_zero = is_div & b_zero;
   assign div_ovf  = is_div & ~op[0] & (opa == {1'b1, {(XLEN-1){1'b0}}}) & (opb == '1);
   assign divu_one = is_div & op[0] & (opb == XLEN'(1));
   assign mul_zero = ((op == 3'b000) | (op == 3'b011)) & ((opa == '0) | b_zero);
   assign early    = div_zero | div_ovf | divu_one | mul_zero;
   // Load the final hi/lo pair directly so FIX sees a finished computation.
   assign prep_hi  = (early & div_zero) ? a_mag : '0;
   assign prep_lo  = !early ? a_mag : (div_zero ? '1 : (mul_zero ? '0 : a_mag));
`else
   assign early    = 1'b0;
   assign prep_hi  = '0;
   assign prep_lo  = a_mag;
`endif

   // Combinational CALC step: RADIX_BITS shift-add or restoring-divide bits
   always_comb begin
      addend = '0;
      for (int k = 0; k < RADIX_BITS; k++) begin
         if (lo[k]) addend = addend + ({{RADIX_BITS{1'b0}}, mag_b} << k);
      end
      psum   = {{RADIX_BITS{1'b0}}, hi} + addend;
      mul_hi = psum[XLEN+RADIX_BITS-1:RADIX_BITS];
      mul_lo = {psum[RADIX_BITS-1:0], lo[XLEN-1:RADIX_BITS]};

      trial = '0;
      rem_t = hi;
      quo_t = lo;
      for (int k = 0; k < RADIX_BITS; k++) begin
         trial = {rem_t, quo_t[XLEN-1]};
         quo_t = quo_t << 1;
         if (trial >= {1'b0, mag_b}) begin
            trial    = trial - {1'b0, mag_b};
            quo_t[0] = 1'b1;
         end
         rem_t = trial[XLEN-1:0];
      end

      step_hi = is_div ? rem_t : mul_hi;
      step_lo = is_div ? quo_t : mul_lo;
   end

   // Sign correction of magnitudes and selection of the architectural result
   always_comb begin
      prod   = {hi, lo};
      prod_s = neg_q ? -prod : prod;
      q_s    = neg_q ? -lo : lo;
      r_s    = neg_r ? -hi : hi;
      case (op)
         3'b000:                 fix_res = prod_s[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fix_res = prod_s[2*XLEN-1:XLEN];
         3'b100, 3'b101:         fix_res = q_s;
         default:                fix_res = r_s;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state logic and execute stall; flush aborts any active operation
   always_comb begin
      state_nx      = state;
      stall_execute = 1'b0;
      case (state)
         IDLE: begin
            stall_execute = phase_execute & muldiv_req;
            if (accept && !flush) state_nx = PREP;
         end
         PREP: begin
            stall_execute = 1'b1;
            if (flush)      state_nx = IDLE;
            else if (early) state_nx = FIX;
            else            state_nx = CALC;
         end
         CALC: begin
            stall_execute = 1'b1;
            if (flush)              state_nx = IDLE;
            else if (cnt == '0)     state_nx = FIX;
         end
         FIX: begin
            stall_execute = 1'b1;
            state_nx      = flush ? IDLE : DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath: latch request, prepare magnitudes, iterate, fix up, publish
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         op              <= '0;
         opa             <= '0;
         opb             <= '0;
         rd              <= '0;
         mag_b           <= '0;
         hi              <= '0;
         lo              <= '0;
         cnt             <= '0;
         neg_q           <= 1'b0;
         neg_r           <= 1'b0;
         result          <= '0;
         muldiv_out_em   <= '0;
         rdsel_em        <= '0;
         muldiv_valid_em <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept && !flush) begin
                  op  <= funct3;
                  opa <= rs1data_de;
                  opb <= rs2data_de;
                  rd  <= rdsel_de;
               end
            end
            PREP: begin
               mag_b <= b_mag;
               hi    <= prep_hi;
               lo    <= prep_lo;
               neg_q <= neg_q_nx;
               neg_r <= a_neg;
               cnt   <= CNT_LAST;
            end
            CALC: begin
               hi  <= step_hi;
               lo  <= step_lo;
               cnt <= cnt - CNT_W'(1);
            end
            FIX: result <= fix_res;
            DONE: begin
               if (!flush) begin
                  muldiv_out_em <= result;
                  rdsel_em      <= rd;
               end
            end
            default: ;
         endcase
         muldiv_valid_em <= (state == DONE) && !flush;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_execute_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_muldiv_unit
// Description : Scoreboard bench for execute_muldiv_unit (XLEN=32, radix 2).
//               Driver issues requests and queues the expected result;
//               a monitor pops and compares on every valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        phase_execute, muldiv_req, flush;
   logic [2:0]  funct3;
   logic [31:0] rs1data_de, rs2data_de;
   logic [4:0]  rdsel_de;
   logic        stall_execute, muldiv_valid_em;
   logic [31:0] muldiv_out_em;
   logic [4:0]  rdsel_em;

   execute_muldiv_unit #(.XLEN(32), .RADIX_BITS(1)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .phase_execute   (phase_execute),
      .muldiv_req      (muldiv_req),
      .funct3          (funct3),
      .rs1data_de      (rs1data_de),
      .rs2data_de      (rs2data_de),
      .rdsel_de        (rdsel_de),
      .flush           (flush),
      .stall_execute   (stall_execute),
      .muldiv_valid_em (muldiv_valid_em),
      .muldiv_out_em   (muldiv_out_em),
      .rdsel_em        (rdsel_em)
   );

   always #5 clk = ~clk;

   int cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   typedef struct {
      logic [31:0] out;
      logic [4:0]  rd;
      int          acc;
      int          lat;
   } exp_t;

   typedef struct packed {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
   } vec_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_out = '0;

   vec_t dir[13] = '{
      '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
      '{3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA},
      '{3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF},
      '{3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
      '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
      '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
      '{3'd5, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC},
      '{3'd7, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001},
      '{3'd4, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF},
      '{3'd5, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF},
      '{3'd6, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678},
      '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
      '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000}
   };

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
      end
   endtask

   // RISC-V M-extension reference using plain wide arithmetic
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
      longint      sa, sbv, p;
      logic [63:0] up;
      int          ia, ib;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      ia  = int'(a);
      ib  = int'(b);
      p   = 0;
      up  = '0;
      case (f)
         3'd0: begin p = sa * sbv; return p[31:0]; end
         3'd1: begin p = sa * sbv; return p[63:32]; end
         3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
         3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return 32'(ia / ib);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(ia % ib);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   // Issue one request; when tracked, queue its expectation and follow the stall
   task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] expv, input bit track);
      exp_t e;
      int   n;
      int   lat;
      lat = 35;
`ifdef MULDIV_EARLY_OUT_EN
      if ((f[2] && b == 0) ||
          ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ||
          ((f == 3'd5 || f == 3'd7) && b == 32'h1) ||
          ((f == 3'd0 || f == 3'd3) && (a == 0 || b == 0)))
         lat = 3;
`endif
      @(negedge clk);
      phase_execute = 1'b1;
      muldiv_req    = 1'b1;
      funct3        = f;
      rs1data_de    = a;
      rs2data_de    = b;
      rdsel_de      = rd;
      #1;
      chk("stall_on_accept", 32'(stall_execute), 32'd1);
      @(posedge clk);
      #1;
      phase_execute = 1'b0;
      muldiv_req    = 1'b0;
      rs1data_de    = $urandom;
      rs2data_de    = $urandom;
      rdsel_de      = 5'($urandom);
      if (track) begin
         e.out = expv;
         e.rd  = rd;
         e.acc = cycle;
         e.lat = lat;
         sb.push_back(e);
         last_out = expv;
         n = 0;
         for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (stall_execute) n++;
            else break;
         end
         chk("stall_cycles", 32'(n), 32'(lat - 1));
         @(negedge clk);
      end
   endtask

   // Monitor: every valid pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (muldiv_valid_em === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid actual=1 required=0 (t=%0t)", $time);
         end else begin
            mon_e = sb.pop_front();
            chk("result", muldiv_out_em, mon_e.out);
            chk("rdsel", 32'(rdsel_em), 32'(mon_e.rd));
            chk("latency", 32'(cycle - mon_e.acc), 32'(mon_e.lat));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [2:0]  f;
      logic [31:0] a, b;
      logic [4:0]  rd;

      rst_n         = 1'b1;
      phase_execute = 1'b0;
      muldiv_req    = 1'b0;
      flush         = 1'b0;
      funct3        = '0;
      rs1data_de    = '0;
      rs2data_de    = '0;
      rdsel_de      = '0;
      repeat (3) @(negedge clk);
      chk("reset_stall", 32'(stall_execute), 32'd0);
      chk("reset_valid", 32'(muldiv_valid_em), 32'd0);
      chk("reset_out", muldiv_out_em, 32'd0);
      chk("reset_rd", 32'(rdsel_em), 32'd0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);

      // Directed vectors with known answers
      for (int i = 0; i < 13; i++)
         do_op(dir[i].f, dir[i].a, dir[i].b, 5'(i + 1), dir[i].r, 1'b1);

      // Randomized operations against the reference model
      for (int i = 0; i < 40; i++) begin
         f  = 3'($urandom_range(0, 7));
         a  = pick();
         b  = pick();
         rd = 5'($urandom);
         do_op(f, a, b, rd, model(f, a, b), 1'b1);
      end

      // Flush ten cycles into a divide
      do_op(3'd4, 32'h0000_1000, 32'h0000_0007, 5'd9, 32'h0, 1'b0);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("flush_stall_low", 32'(stall_execute), 32'd0);
      chk("flush_out_hold", muldiv_out_em, last_out);
      repeat (40) @(negedge clk);
      chk("flush_out_hold_late", muldiv_out_em, last_out);
      do_op(3'd0, 32'h3, 32'h5, 5'd17, 32'h0000_000F, 1'b1);

      // Asynchronous reset in the middle of a multiply
      do_op(3'd0, 32'h0000_1234, 32'h0000_5678, 5'd21, 32'h0, 1'b0);
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("midreset_stall", 32'(stall_execute), 32'd0);
      chk("midreset_valid", 32'(muldiv_valid_em), 32'd0);
      chk("midreset_out", muldiv_out_em, 32'd0);
      chk("midreset_rd", 32'(rdsel_em), 32'd0);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (45) @(negedge clk);
      do_op(3'd5, 32'd100, 32'd7, 5'd30, 32'd14, 1'b1);

      repeat (5) @(negedge clk);
      chk("queue_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/execute_muldiv_unit.md
Name: execute_muldiv_unit

Overview:
- Iterative RV32M/RV64M multiply/divide engine for the execute phase of the multi-cycle core.
- Launched from the execute phase alongside the ALU/comparator path.
- Holds the state machine in execute through stall_execute until the result is ready.
- Delivers a registered result plus rd select to the memory-access stage, generalising execute from single-cycle ALU to multi-cycle arithmetic.

Parameters:
- XLEN, 32, operand/result width; must be even, ≥8.
- RADIX_BITS, 1, quotient/multiplier bits retired per CALC cycle; 1 or 2; XLEN % RADIX_BITS == 0.
- ITER, XLEN/RADIX_BITS, derived (localparam): CALC cycle count.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset, asynchronous, active-high (rst_n=1 resets).
- phase_execute  in  1  execute-phase strobe from state machine.
- muldiv_req  in  1  decoded op is an M-extension op; sampled with phase_execute.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1data_de  in  XLEN  operand A.
- rs2data_de  in  XLEN  operand B.
- rdsel_de  in  5  destination register.
- flush  in  1  synchronous kill of an in-flight op.
- stall_execute  out  1  hold execute phase.
- muldiv_valid_em  out  1  one-cycle pulse: result updated.
- muldiv_out_em  out  XLEN  result.
- rdsel_em  out  5  destination of the result.

Behaviour:
- Reset: state=IDLE; stall_execute=0; muldiv_valid_em=0; muldiv_out_em=0; rdsel_em=0; all internals 0.
- Accept: in IDLE, phase_execute & muldiv_req at posedge clk.
  - Latch funct3, operands and rdsel; go to PREP.
  - stall_execute is combinationally 1 in that same cycle (IDLE & phase_execute & muldiv_req).
  - It stays 1 through PREP, CALC and FIX.
- PREP (1 cycle):
  - Form magnitudes per signedness. MULH: both signed. MULHSU: rs1 signed, rs2 unsigned. DIV/REM signed. Others unsigned.
  - Record result sign. Clear accumulator; load counter=ITER-1.
- CALC (ITER cycles):
  - Multiply: shift-add, RADIX_BITS multiplier bits per cycle into a 2*XLEN product.
  - Divide: restoring, RADIX_BITS quotient bits per cycle.
  - Counter decrements; at 0 go to FIX.
- FIX (1 cycle): apply two's-complement sign correction, then select the result.
  - MUL: low XLEN of product.
  - MULH/MULHSU/MULHU: high XLEN of product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder; its sign follows the dividend.
- DONE (1 cycle):
  - muldiv_out_em and rdsel_em are registered.
  - muldiv_valid_em=1; stall_execute=0; next state IDLE.
  - muldiv_out_em/rdsel_em hold until the next DONE.
- Latency: accept edge to valid = ITER+3 clocks (35 for XLEN=32, RADIX_BITS=1).
- Divide by zero: quotient = all ones (DIVU and DIV); remainder = dividend.
- Signed overflow, rs1 = -2^(XLEN-1) and rs2 = -1: DIV result = rs1; REM result = 0.
- X operands propagate; no X-masking is required.
- A new request while not IDLE is ignored. The state machine cannot issue one, because stall holds it.
- flush=1 in any non-IDLE state: next state IDLE; stall_execute falls the next cycle; no valid pulse; outputs unchanged.
- flush in IDLE has no effect. flush together with an accept wins: no launch.
- Async reset mid-operation: immediate return to the reset values; no pulse afterwards.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- When defined:
  - Divide-by-zero, signed overflow, or rs2==1 (unsigned ops) bypass CALC: PREP goes straight to FIX, so latency is 3 clocks.
  - MUL/MULHU with either operand 0 also bypass CALC.
- When not defined: every op takes exactly ITER+3 clocks, and results are identical.

Test Plan:
- MULHU: rs1=FFFF_FFFF, rs2=FFFF_FFFF → muldiv_out_em=FFFF_FFFE, valid 35 clocks after accept, stall_execute high for 34 clocks then low.
- MUL/MULH: rs1=FFFF_FFFE (-2), rs2=0000_0003 → MUL gives FFFF_FFFA; MULH gives FFFF_FFFF; MULHSU with rs1=-2, rs2=FFFF_FFFF gives FFFF_FFFE.
- DIV/REM signs: rs1=FFFF_FFF9 (-7), rs2=0000_0002 → DIV FFFF_FFFD (-3); REM FFFF_FFFF (-1); DIVU 7FFF_FFFC; REMU 0000_0001.
- Boundaries:
  - rs2=0, rs1=1234_5678 → DIV/DIVU FFFF_FFFF; REM 1234_5678.
  - rs1=8000_0000, rs2=FFFF_FFFF → DIV 8000_0000; REM 0.
  - With MULDIV_EARLY_OUT_EN, valid arrives 3 clocks after accept.
- flush asserted 10 cycles into a DIV → no valid pulse, muldiv_out_em keeps its prior value, stall low the next cycle, and a following MUL 3×5 returns 0000_000F.
- rst_n pulsed high mid-MUL → all outputs 0 immediately; stall 0; no stray valid pulse after reset is released.
